key_xlat_engine: RTL

//  Parametrised execution engine for the key/translate operation set (operation_t): key register file,

---
 rtl/key_xlat_engine_pkg.sv | 38 +++
 rtl/key_xlat_engine_if.sv | 32 +++
 rtl/key_xlat_engine_xlat_table.sv | 27 ++
 rtl/key_xlat_engine.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/key_xlat_engine_pkg.sv
// Shared types for the key/translate engine: opcodes, FSM states, defaults.
// Optional feature macro used by the top: BP_COUNT_EN.
package key_xlat_engine_pkg;

    localparam int DATA_WIDTH_DEF = 16;
    localparam int NUM_KEYS_DEF   = 8;
    localparam int XLAT_DW_DEF    = 8;
    localparam int TAG_WIDTH_DEF  = 2;
    localparam int DLY_WIDTH_DEF  = 4;

    typedef enum logic [3:0] {
        OP_NOP       = 4'd0,
        OP_RESET     = 4'd1,
        OP_STORE_DLY = 4'd2,
        OP_KEY_STORE = 4'd3,
        OP_STORE_TBL = 4'd4,
        OP_ROTL      = 4'd8,
        OP_ROTR      = 4'd9,
        OP_XOR       = 4'd10,
        OP_TBL       = 4'd11,
        OP_KS_ROTL   = 4'd12,
        OP_KS_ROTR   = 4'd13,
        OP_KS_XOR    = 4'd14,
        OP_KS_TBL    = 4'd15
    } operation_t;

    typedef enum logic [1:0] {
        ST_RST,
        ST_D1,
        ST_D2,
        ST_OUT
    } state_t;

    function automatic logic is_reserved(input logic [3:0] op);
        return (op >= 4'd5) && (op <= 4'd7);
    endfunction

endpackage

// File: rtl/key_xlat_engine_if.sv
// Request/result handshake bundle between transactor, engine and checker.
// The engine uses the slave modport; the stimulus side uses master.
interface key_xlat_engine_if #(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_KEYS   = 8,
    parameter int TAG_WIDTH  = 2
);
    localparam int KW = $clog2(NUM_KEYS);

    logic                  in_valid;
    logic                  in_ready;
    logic [3:0]            in_op;
    logic [KW-1:0]         in_key_sel;
    logic [TAG_WIDTH-1:0]  in_tag;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_result;
    logic [TAG_WIDTH-1:0]  out_tag;
    logic                  op_err;

    modport master (
        output in_valid, in_op, in_key_sel, in_tag, in_data, out_ready,
        input  in_ready, out_valid, out_result, out_tag, op_err
    );

    modport slave (
        input  in_valid, in_op, in_key_sel, in_tag, in_data, out_ready,
        output in_ready, out_valid, out_result, out_tag, op_err
    );

endinterface

// File: rtl/key_xlat_engine_xlat_table.sv
// Translation table: one synchronous write port, NRD combinational reads.
// Contents are deliberately not reset.
module key_xlat_engine_xlat_table #(
    parameter int XLAT_DW = 8,
    parameter int NRD     = 2
) (
    input  logic                   clk,
    input  logic                   we_i,
    input  logic [XLAT_DW-1:0]     waddr_i,
    input  logic [XLAT_DW-1:0]     wdata_i,
    input  logic [NRD*XLAT_DW-1:0] raddr_i,
    output logic [NRD*XLAT_DW-1:0] rdata_o
);
    localparam int XLAT_SIZE = 2 ** XLAT_DW;

    logic [XLAT_DW-1:0] mem_q [XLAT_SIZE];

    always_ff @(posedge clk) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
    end

    for (genvar i = 0; i < NRD; i++) begin : g_rd
        assign rdata_o[i*XLAT_DW +: XLAT_DW] =
            mem_q[raddr_i[i*XLAT_DW +: XLAT_DW]];
    end

endmodule

// File: rtl/key_xlat_engine.sv
// Key/translate execution engine: key file, xlat table, rotate/xor/translate.
// Define BP_COUNT_EN to add the bp_count backpressure cycle counter.
module key_xlat_engine
    import key_xlat_engine_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int NUM_KEYS   = NUM_KEYS_DEF,
    parameter int XLAT_DW    = XLAT_DW_DEF,
    parameter int TAG_WIDTH  = TAG_WIDTH_DEF,
    parameter int DLY_WIDTH  = DLY_WIDTH_DEF
) (
    input  logic clk,
    input  logic reset,
`ifdef BP_COUNT_EN
    output logic [15:0] bp_count,
`endif
    key_xlat_engine_if.slave bus
);
    localparam int KW  = $clog2(NUM_KEYS);
    localparam int R   = $clog2(DATA_WIDTH);
    localparam int NRD = DATA_WIDTH / XLAT_DW;

    state_t                state_q;
    logic [3:0]            op_q;
    logic [KW-1:0]         sel_q;
    logic [TAG_WIDTH-1:0]  tag_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic [DATA_WIDTH-1:0] keys_q [NUM_KEYS];
    logic [DLY_WIDTH-1:0]  dly_q;
    logic [DLY_WIDTH-1:0]  cnt_q;
    logic [DATA_WIDTH-1:0] res_q;
    logic [DATA_WIDTH-1:0] res_d;
    logic                  out_valid_q;
    logic                  op_err_q;
    logic [DATA_WIDTH-1:0] key_rd;
    logic [DATA_WIDTH-1:0] tbl_rd;
    logic                  tbl_we;

    function automatic logic [DATA_WIDTH-1:0] rotl(
        input logic [DATA_WIDTH-1:0] d, input logic [R-1:0] a);
        logic [2*DATA_WIDTH-1:0] w;
        w = {d, d} << a;
        return w[2*DATA_WIDTH-1:DATA_WIDTH];
    endfunction

    function automatic logic [DATA_WIDTH-1:0] rotr(
        input logic [DATA_WIDTH-1:0] d, input logic [R-1:0] a);
        logic [2*DATA_WIDTH-1:0] w;
        w = {d, d} >> a;
        return w[DATA_WIDTH-1:0];
    endfunction

    assign key_rd = keys_q[sel_q];
    assign tbl_we = (state_q == ST_D1) && (op_q == OP_STORE_TBL) && !reset;

    key_xlat_engine_xlat_table #(
        .XLAT_DW(XLAT_DW),
        .NRD    (NRD)
    ) u_tbl (
        .clk    (clk),
        .we_i   (tbl_we),
        .waddr_i(data_q[2*XLAT_DW-1:XLAT_DW]),
        .wdata_i(data_q[XLAT_DW-1:0]),
        .raddr_i(data_q),
        .rdata_o(tbl_rd)
    );

    always_comb begin
        res_d = '0;
        case (op_q)
            OP_ROTL, OP_KS_ROTL: res_d = rotl(data_q, key_rd[R-1:0]);
            OP_ROTR, OP_KS_ROTR: res_d = rotr(data_q, key_rd[R-1:0]);
            OP_XOR,  OP_KS_XOR:  res_d = data_q ^ key_rd;
            OP_TBL,  OP_KS_TBL:  res_d = tbl_rd;
            default:             res_d = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_RST;
            op_q        <= OP_NOP;
            sel_q       <= '0;
            tag_q       <= '0;
            data_q      <= '0;
            dly_q       <= '0;
            cnt_q       <= '0;
            res_q       <= '0;
            out_valid_q <= 1'b0;
            op_err_q    <= 1'b0;
            for (int i = 0; i < NUM_KEYS; i++) keys_q[i] <= '0;
        end else begin
            op_err_q <= 1'b0;
            unique case (state_q)
                ST_RST: if (bus.in_valid) begin
                    op_q     <= bus.in_op;
                    sel_q    <= bus.in_key_sel;
                    tag_q    <= bus.in_tag;
                    data_q   <= bus.in_data;
                    op_err_q <= is_reserved(bus.in_op);
                    state_q  <= ST_D1;
                end
                ST_D1: begin
                    case (op_q)
                        OP_RESET: begin
                            dly_q <= '0;
                            for (int i = 0; i < NUM_KEYS; i++) keys_q[i] <= '0;
                        end
                        OP_STORE_DLY: dly_q <= data_q[DLY_WIDTH-1:0];
                        OP_KEY_STORE: keys_q[sel_q] <= data_q;
                        default: ;
                    endcase
                    // Opcodes 8..15 produce a result; everything else retires here.
                    if (op_q[3]) begin
                        res_q   <= res_d;
                        cnt_q   <= dly_q;
                        state_q <= ST_D2;
                    end else begin
                        state_q <= ST_RST;
                    end
                end
                ST_D2: begin
                    if (cnt_q == '0) begin
                        out_valid_q <= 1'b1;
                        state_q     <= ST_OUT;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                ST_OUT: if (bus.out_ready) begin
                    out_valid_q <= 1'b0;
                    state_q     <= ST_RST;
                    if (op_q[2]) keys_q[sel_q] <= res_q;
                end
                default: state_q <= ST_RST;
            endcase
        end
    end

`ifdef BP_COUNT_EN
    logic [15:0] bp_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            bp_q <= '0;
        end else if (state_q == ST_D1 && op_q == OP_RESET) begin
            bp_q <= '0;
        end else if (out_valid_q && !bus.out_ready && bp_q != 16'hFFFF) begin
            bp_q <= bp_q + 16'd1;
        end
    end

    assign bp_count = bp_q;
`endif

    assign bus.in_ready   = (state_q == ST_RST);
    assign bus.out_valid  = out_valid_q;
    assign bus.out_result = res_q;
    assign bus.out_tag    = tag_q;
    assign bus.op_err     = op_err_q;

endmodule
